// File: rtl/l1_request_arbiter.sv
// l1_request_arbiter: round-robin arbiter sharing one L1 memory port, with in-order read response routing
module l1_request_arbiter #(
    parameter int NUM_REQUESTERS = 4,
    parameter int MAX_BURST      = 4,
    parameter int BURST_W        = $clog2(MAX_BURST),
    parameter int RD_FIFO_DEPTH  = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_REQUESTERS-1:0]           req_valid,
    output logic [NUM_REQUESTERS-1:0]           req_ready,
    input  logic [NUM_REQUESTERS*32-1:0]        req_addr,
    input  logic [NUM_REQUESTERS-1:0]           req_rnw,
    input  logic [NUM_REQUESTERS*BURST_W-1:0]   req_size,
    input  logic [NUM_REQUESTERS*32-1:0]        req_wdata,
    input  logic [NUM_REQUESTERS*4-1:0]         req_be,
    output logic                                mem_request,
    input  logic                                mem_ack,
    output logic [31:0]                         mem_addr,
    output logic                                mem_rnw,
    output logic [BURST_W-1:0]                  mem_size,
    output logic [31:0]                         mem_wdata,
    output logic [3:0]                          mem_be,
    input  logic                                mem_rd_valid,
    input  logic [31:0]                         mem_rd_data,
    output logic [NUM_REQUESTERS-1:0]           rsp_valid,
    output logic [31:0]                         rsp_data,
    output logic                                rsp_last,
    output logic                                busy
);
    localparam int ID_W  = $clog2(NUM_REQUESTERS);
    localparam int PTR_W = $clog2(RD_FIFO_DEPTH);

    typedef enum logic {IDLE, REQ} state_t;

    state_t                    state_q, state_d;
    logic [NUM_REQUESTERS-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]           gnt_id_q, gnt_id_d, rr_q, rr_d, win_id, head_id;
    logic                      win_valid;
    logic [NUM_REQUESTERS-1:0] elig;
    logic [ID_W-1:0]           fifo_id_q [RD_FIFO_DEPTH];
    logic [BURST_W-1:0]        fifo_sz_q [RD_FIFO_DEPTH];
    logic [PTR_W:0]            wr_ptr_q, rd_ptr_q;
    logic [BURST_W-1:0]        cnt_q, cnt_d, head_sz;
    logic                      fifo_empty, fifo_full, acc, push, pop, rd_word;

    assign fifo_empty = wr_ptr_q == rd_ptr_q;
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) && (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    // A full read FIFO only holds back reads; writes need no return slot
    assign elig       = req_valid & (~req_rnw | {NUM_REQUESTERS{~fifo_full}});

    // First eligible client at or after the round-robin pointer
    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
        for (int k = 0; k < NUM_REQUESTERS; k++) begin
            if (!win_valid && elig[(int'(rr_q) + k) % NUM_REQUESTERS]) begin
                win_valid = 1'b1;
                win_id    = ID_W'((int'(rr_q) + k) % NUM_REQUESTERS);
            end
        end
    end

    assign mem_request = state_q == REQ;
    assign acc         = mem_request && mem_ack;
    assign req_ready   = acc ? gnt_q : '0;
    assign mem_addr    = req_addr[32*int'(gnt_id_q) +: 32];
    assign mem_rnw     = req_rnw[gnt_id_q];
    assign mem_size    = mem_rnw ? req_size[BURST_W*int'(gnt_id_q) +: BURST_W] : '0;
    assign mem_wdata   = req_wdata[32*int'(gnt_id_q) +: 32];
    assign mem_be      = req_be[4*int'(gnt_id_q) +: 4];
    assign push        = acc && mem_rnw;

    // Grant is latched in IDLE and held until memory accepts it
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        rr_d     = rr_q;
        if (state_q == IDLE && win_valid) begin
            state_d  = REQ;
            gnt_d    = NUM_REQUESTERS'(1) << win_id;
            gnt_id_d = win_id;
        end else if (acc) begin
            state_d = IDLE;
            gnt_d   = '0;
            rr_d    = ID_W'((int'(gnt_id_q) + 1) % NUM_REQUESTERS);
        end
    end

    assign head_id   = fifo_id_q[rd_ptr_q[PTR_W-1:0]];
    assign head_sz   = fifo_sz_q[rd_ptr_q[PTR_W-1:0]];
    assign rd_word   = mem_rd_valid && !fifo_empty;
    assign rsp_valid = rd_word ? NUM_REQUESTERS'(1) << head_id : '0;
    assign rsp_data  = mem_rd_data;
    assign rsp_last  = rd_word && (cnt_q == head_sz);
    assign pop       = rsp_last;
    assign cnt_d     = pop ? '0 : rd_word ? cnt_q + 1'b1 : cnt_q;
    assign busy      = mem_request || !fifo_empty;

    // Control state, pointers and word counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            rr_q     <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            rr_q     <= rr_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(push);
            rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(pop);
        end
    end

    // FIFO payload; entry validity lives in the pointers, so no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_id_q[wr_ptr_q[PTR_W-1:0]] <= gnt_id_q;
            fifo_sz_q[wr_ptr_q[PTR_W-1:0]] <= mem_size;
        end
    end

    a_no_stray_rd: assert property (@(posedge clk) disable iff (!rst_n) mem_rd_valid |-> !fifo_empty);
    a_hold_valid:  assert property (@(posedge clk) disable iff (!rst_n) state_q == REQ |-> req_valid[gnt_id_q]);
endmodule
